// File: rtl/inst_encoder.sv
// Packs decoded R/I/S/B fields into 32-bit RV64I words; out-of-range immediates are dropped and flagged.
// Latency 1 cycle accept->output; in_ready drops when the registered FIFO count is full, with no same-cycle pop bypass.

module inst_encoder_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [W-1:0]               i_push_dat,
    input  logic                       i_pop,
    output logic [W-1:0]               o_head_dat,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_dat;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_count    = r_count;
endmodule

module inst_encoder #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int BASE_ADDR  = 0,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_fmt,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_rs1,
    input  logic [4:0]            in_rs2,
    input  logic [2:0]            in_funct3,
    input  logic [6:0]            in_funct7,
    input  logic [DATA_WIDTH-1:0] in_imm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_inst,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  err,
    output logic [7:0]            err_count
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = ADDR_WIDTH + 32;
    localparam logic [CW-1:0]         L_DEPTH = CW'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] L_BASE  = ADDR_WIDTH'(BASE_ADDR);

    localparam logic [1:0] FMT_R = 2'b00;
    localparam logic [1:0] FMT_I = 2'b01;
    localparam logic [1:0] FMT_S = 2'b10;
    localparam logic [1:0] FMT_B = 2'b11;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_last_inst;
    logic [ADDR_WIDTH-1:0] r_last_addr;
    logic                  r_err;
    logic [7:0]            r_err_count;

    logic [31:0]   w_inst;
    logic          w_imm_ok;
    logic          w_imm12_ok;
    logic          w_imm13_ok;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_count;
    logic [EW-1:0] w_head;

    // A 12-bit (or 13-bit) signed value fits iff every bit above the sign position matches it.
    assign w_imm12_ok = (&in_imm[DATA_WIDTH-1:11]) | ~(|in_imm[DATA_WIDTH-1:11]);
    assign w_imm13_ok = ((&in_imm[DATA_WIDTH-1:12]) | ~(|in_imm[DATA_WIDTH-1:12])) & ~in_imm[0];

    always_comb begin
        w_inst   = '0;
        w_imm_ok = 1'b1;
        case (in_fmt)
            FMT_R: begin
                w_inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
            end
            FMT_I: begin
                w_inst   = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
                w_imm_ok = w_imm12_ok;
            end
            FMT_S: begin
                w_inst   = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
                w_imm_ok = w_imm12_ok;
            end
            FMT_B: begin
                w_inst   = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], 7'b1100011};
                w_imm_ok = w_imm13_ok;
            end
            default: begin
                w_inst   = '0;
                w_imm_ok = 1'b1;
            end
        endcase
    end

    assign in_ready  = (w_count < L_DEPTH);
    assign out_valid = (w_count != '0);
    assign w_accept  = in_valid & in_ready;
    assign w_push    = w_accept & w_imm_ok;
    assign w_pop     = out_valid & out_ready;

    inst_encoder_fifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_push_dat ({r_addr, w_inst}),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_count    (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= L_BASE;
            r_last_inst <= '0;
            r_last_addr <= L_BASE;
            r_err       <= 1'b0;
            r_err_count <= '0;
        end else begin
            if (w_push) begin
                r_addr <= r_addr + ADDR_WIDTH'(4);
            end
            // Remember the departing head so the outputs hold it once the FIFO drains.
            if (w_pop) begin
                r_last_inst <= w_head[31:0];
                r_last_addr <= w_head[EW-1:32];
            end
            r_err <= w_accept & ~w_imm_ok;
            if (w_accept && !w_imm_ok && r_err_count != 8'hFF) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign out_inst  = out_valid ? w_head[31:0]    : r_last_inst;
    assign out_addr  = out_valid ? w_head[EW-1:32] : r_last_addr;
    assign err       = r_err;
    assign err_count = r_err_count;
endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;
    localparam int DW    = 64;
    localparam int AW    = 32;
    localparam int DEPTH = 2;
    localparam int BASE  = 0;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_fmt;
    logic [4:0]    in_rd;
    logic [4:0]    in_rs1;
    logic [4:0]    in_rs2;
    logic [2:0]    in_funct3;
    logic [6:0]    in_funct7;
    logic [DW-1:0] in_imm;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_inst;
    logic [AW-1:0] out_addr;
    logic          err;
    logic [7:0]    err_count;

    inst_encoder #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_addr  (out_addr),
        .err       (err),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_pass = 0;
    int          n_fail = 0;
    logic [63:0] m_q[$];
    logic [31:0] m_addr;
    logic [63:0] m_last;
    logic        m_err;
    int          m_cnt;
    bit          chk = 0;
    bit          last_acc;

    function automatic logic [31:0] ref_enc(input logic [1:0] fmt, input longint rd, input longint rs1,
                                            input longint rs2, input longint f3, input longint f7,
                                            input longint imm);
        longint w;
        case (fmt)
            2'd0: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h33;
            2'd1: w = ((imm & 'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h03;
            2'd2: w = (((imm >> 5) & 'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                      | ((imm & 'h1F) << 7) | 'h23;
            default: w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 'h3F) << 25) | (rs2 << 20)
                         | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 'hF) << 8)
                         | (((imm >> 11) & 1) << 7) | 'h63;
        endcase
        return w[31:0];
    endfunction

    function automatic bit ref_ok(input logic [1:0] fmt, input longint imm);
        case (fmt)
            2'd0:    return 1'b1;
            2'd1,
            2'd2:    return (imm >= -2048) && (imm <= 2047);
            default: return (imm >= -4096) && (imm <= 4094) && ((imm & 1) == 0);
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: compare outputs with the model, then advance both across the edge.
    task automatic tick();
        bit          acc;
        bit          pop;
        bit          ok;
        logic [31:0] w;
        if (chk) begin
            check("in_ready", 64'(in_ready), 64'(m_q.size() < DEPTH));
            check("out_valid", 64'(out_valid), 64'(m_q.size() > 0));
            if (m_q.size() > 0) begin
                check("out_inst", 64'(out_inst), 64'(m_q[0][31:0]));
                check("out_addr", 64'(out_addr), 64'(m_q[0][63:32]));
            end else begin
                check("hold_inst", 64'(out_inst), 64'(m_last[31:0]));
                check("hold_addr", 64'(out_addr), 64'(m_last[63:32]));
            end
            check("err", 64'(err), 64'(m_err));
            check("err_count", 64'(err_count), 64'(m_cnt));
        end
        acc = in_valid && (m_q.size() < DEPTH);
        pop = out_ready && (m_q.size() > 0);
        ok  = ref_ok(in_fmt, longint'($signed(in_imm)));
        w   = ref_enc(in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, longint'($signed(in_imm)));
        @(posedge clk);
        #1;
        if (rst) begin
            m_q.delete();
            m_addr = BASE;
            m_last = {32'(BASE), 32'h0};
            m_err  = 1'b0;
            m_cnt  = 0;
        end else begin
            if (pop) m_last = m_q.pop_front();
            m_err = acc && !ok;
            if (acc && ok) begin
                m_q.push_back({m_addr, w});
                m_addr = m_addr + 4;
            end else if (acc && m_cnt < 255) begin
                m_cnt++;
            end
        end
        last_acc = acc && !rst;
    endtask

    task automatic drive(input logic [1:0] fmt, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                         input longint imm);
        in_valid  = 1'b1;
        in_fmt    = fmt;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_funct7 = f7;
        in_imm    = imm;
    endtask

    task automatic push_wait();
        for (int k = 0; k < 10; k++) begin
            tick();
            if (last_acc) break;
        end
        check("accept_timeout", 64'(last_acc), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        chk = 1;
    endtask

    longint edge_imm [9] = '{-2048, -2049, 2047, 2048, -4096, -4097, 4094, 4095, 4096};

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_fmt = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_funct3 = '0; in_funct7 = '0; in_imm = '0;
        tick();
        do_reset();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_inst", 64'(out_inst), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        drive(2'd0, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 0);
        push_wait();
        check("r_inst", 64'(out_inst), 64'h003100B3);
        check("r_addr", 64'(out_addr), 64'h0);
        tick();

        do_reset();
        drive(2'd1, 5'd5, 5'd2, 5'd0, 3'd3, 7'd0, -4);
        push_wait();
        check("i_inst", 64'(out_inst), 64'hFFC13283);
        drive(2'd2, 5'd0, 5'd2, 5'd5, 3'd3, 7'd0, 16);
        push_wait();
        check("s_inst", 64'(out_inst), 64'h00513823);
        check("s_addr", 64'(out_addr), 64'h4);
        tick();

        do_reset();
        drive(2'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -8);
        push_wait();
        check("b_inst", 64'(out_inst), 64'hFE208CE3);
        drive(2'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 3);
        push_wait();
        check("b_odd_err", 64'(err), 64'd1);
        check("b_odd_cnt", 64'(err_count), 64'd1);
        drive(2'd0, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 0);
        push_wait();
        check("after_err_addr", 64'(out_addr), 64'h4);
        tick();

        do_reset();
        drive(2'd1, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 2048);
        push_wait();
        drive(2'd2, 5'd0, 5'd1, 5'd1, 3'd0, 7'd0, -2049);
        push_wait();
        check("range_err2", 64'(err), 64'd1);
        check("range_cnt2", 64'(err_count), 64'd2);
        check("range_empty", 64'(out_valid), 64'd0);
        drive(2'd1, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 2047);
        push_wait();
        check("imm_max", 64'(out_inst[31:20]), 64'h7FF);
        tick();

        do_reset();
        out_ready = 1'b0;
        drive(2'd0, 5'd1, 5'd1, 5'd1, 3'd1, 7'd1, 0);
        push_wait();
        drive(2'd0, 5'd2, 5'd2, 5'd2, 3'd2, 7'd2, 0);
        push_wait();
        drive(2'd0, 5'd3, 5'd3, 5'd3, 3'd3, 7'd3, 0);
        tick();
        tick();
        check("full_ready", 64'(in_ready), 64'd0);
        check("full_head_addr", 64'(out_addr), 64'h0);
        out_ready = 1'b1;
        tick();
        check("pop_ready_lag", 64'(out_addr), 64'h4);
        push_wait();
        repeat (4) tick();
        check("third_addr", 64'(m_last[63:32]), 64'h8);
        check("drain_addr", 64'(out_addr), 64'h8);

        out_ready = 1'b0;
        drive(2'd0, 5'd4, 5'd4, 5'd4, 3'd4, 7'd4, 0);
        push_wait();
        drive(2'd0, 5'd5, 5'd5, 5'd5, 3'd5, 7'd5, 0);
        push_wait();
        do_reset();
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        drive(2'd0, 5'd6, 5'd6, 5'd6, 3'd6, 7'd6, 0);
        push_wait();
        check("midrst_addr", 64'(out_addr), 64'(BASE));
        drive(2'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 3);
        repeat (256) tick();
        in_valid = 1'b0;
        tick();
        check("err_sat", 64'(err_count), 64'd255);

        do_reset();
        for (int c = 0; c < 600; c++) begin
            longint imm;
            case ($urandom % 4)
                0:       imm = longint'($urandom_range(10000)) - 5000;
                1:       imm = {$urandom, $urandom};
                2:       imm = edge_imm[$urandom % 9];
                default: imm = longint'($urandom_range(32)) - 16;
            endcase
            drive(2'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), imm);
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            rst       = (c == 300);
            tick();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end
endmodule
